// File: rtl/ehgu_mavg.sv
// ehgu_mavg -- running moving-average over a power-of-two window.
//
// The block keeps a registered running sum of the last WINDOW accepted
// samples. The caller supplies the sample that leaves the window on
// data_dly. That value comes from an external delay line that shifts on the
// same en. The block therefore needs no sample memory of its own.
//
// Optional feature macro: EHGU_MAVG_ROUND_EN
//   defined   : avg_out = (sum_out + WINDOW/2) >> log2(WINDOW)  (round half up)
//   undefined : avg_out = sum_out >> log2(WINDOW)               (truncate)
//
// Parameters
//   WIDTH     sample width in bits (unsigned)
//   WINDOW    window length in accepted samples, power of two, 2..1024
//
// Ports
//   clk       single clock, all state on rising edge
//   rstn      asynchronous active-low reset
//   en        sample accept strobe, one sample per high cycle
//   clr       synchronous window restart; takes priority over en
//   data_in   newest sample
//   data_dly  sample accepted WINDOW en-cycles earlier (from the delay line)
//   sum_out   registered running window sum, WIDTH+log2(WINDOW) bits
//   avg_out   sum_out / WINDOW, combinational from sum_out
//   out_valid window fully populated (high while in RUN)
//   err       sticky: data_dly was inconsistent and the sum would go negative
//
// Handshake: there is no back-pressure. Every cycle with en high (and clr
// low) consumes exactly one data_in/data_dly pair. Outputs are valid every
// cycle. Each accepted sample is reflected in sum_out one clock later.
module ehgu_mavg #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 16
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              en,
    input  logic                              clr,
    input  logic [WIDTH-1:0]                  data_in,
    input  logic [WIDTH-1:0]                  data_dly,
    output logic [WIDTH+$clog2(WINDOW)-1:0]   sum_out,
    output logic [WIDTH-1:0]                  avg_out,
    output logic                              out_valid,
    output logic                              err
);

    localparam int LOGW = $clog2(WINDOW);
    localparam int SW   = WIDTH + LOGW;
    // Two spare bits: one catches a carry past SW, one is the sign.
    localparam int XW   = SW + 2;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [LOGW-1:0]   fcnt;
    logic [LOGW-1:0]   fcnt_nxt;
    logic [SW-1:0]     sum_nxt;
    logic              valid_nxt;
    logic              err_nxt;
    logic [XW-1:0]     run_res;

    // RUN update computed with headroom.
    // run_res[XW-1] set means the result is negative (inconsistent data_dly).
    // run_res[XW-2] set means the result is above the sum range, which also
    // only happens with inconsistent data_dly.
    assign run_res = {2'b00, sum_out}
                   + {{(XW-WIDTH){1'b0}}, data_in}
                   - {{(XW-WIDTH){1'b0}}, data_dly};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= FILL;
            fcnt      <= '0;
            sum_out   <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            fcnt      <= fcnt_nxt;
            sum_out   <= sum_nxt;
            out_valid <= valid_nxt;
            err       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        sum_nxt   = sum_out;
        valid_nxt = out_valid;
        err_nxt   = err;
        if (clr) begin
            // Restart wins over a coincident sample, which is discarded.
            state_nxt = FILL;
            fcnt_nxt  = '0;
            sum_nxt   = '0;
            valid_nxt = 1'b0;
            err_nxt   = 1'b0;
        end else if (en) begin
            unique case (state)
                FILL: begin
                    // The delay line holds garbage until the window is full.
                    sum_nxt = sum_out + {{LOGW{1'b0}}, data_in};
                    if (fcnt == LOGW'(WINDOW - 1)) begin
                        state_nxt = RUN;
                        fcnt_nxt  = '0;
                        valid_nxt = 1'b1;
                    end else begin
                        fcnt_nxt  = fcnt + 1'b1;
                    end
                end
                RUN: begin
                    if (run_res[XW-1]) begin
                        sum_nxt = '0;
                        err_nxt = 1'b1;
                    end else if (run_res[XW-2]) begin
                        sum_nxt = '1;
                    end else begin
                        sum_nxt = run_res[SW-1:0];
                    end
                end
                default: begin
                    state_nxt = FILL;
                end
            endcase
        end
    end

`ifdef EHGU_MAVG_ROUND_EN
    logic [SW:0]    rnd_sum;
    logic [WIDTH:0] rnd_q;

    assign rnd_sum = {1'b0, sum_out} + (SW+1)'(WINDOW / 2);
    assign rnd_q   = (WIDTH+1)'(rnd_sum >> LOGW);
    // A consistent window never rounds past the maximum. The clamp only
    // covers a saturated sum.
    assign avg_out = rnd_q[WIDTH] ? {WIDTH{1'b1}} : rnd_q[WIDTH-1:0];
`else
    assign avg_out = sum_out[SW-1:LOGW];
`endif

endmodule

// File: tb/tb_ehgu_mavg.sv
// Bench for ehgu_mavg (WIDTH=8, WINDOW=16).
module tb_ehgu_mavg;

    localparam int WIDTH  = 8;
    localparam int WINDOW = 16;
    localparam int SW     = 12;
    localparam int EW     = SW + WIDTH + 2;
    localparam int SMAX   = (1 << SW) - 1;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              en = 1'b0;
    logic              clr = 1'b0;
    logic [WIDTH-1:0]  data_in = '0;
    logic [WIDTH-1:0]  data_dly = '0;
    logic [SW-1:0]     sum_out;
    logic [WIDTH-1:0]  avg_out;
    logic              out_valid;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    ehgu_mavg #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr),
        .data_in(data_in), .data_dly(data_dly),
        .sum_out(sum_out), .avg_out(avg_out),
        .out_valid(out_valid), .err(err)
    );

    // ---------------- reference model ----------------
    // The model works on plain integers: count of samples since restart,
    // the window sum, and the sticky error.
    int m_sum = 0;
    int m_cnt = 0;
    bit m_err = 0;
    int hist[$];

    function automatic int model_avg(input int s);
        int a;
`ifdef EHGU_MAVG_ROUND_EN
        a = (s + WINDOW / 2) / WINDOW;
        if (a > 255) a = 255;
`else
        a = s / WINDOW;
`endif
        return a;
    endfunction

    function automatic void model_step(input bit e, input bit c, input int d, input int q);
        int t;
        if (c) begin
            m_sum = 0; m_cnt = 0; m_err = 0;
        end else if (e) begin
            if (m_cnt < WINDOW) begin
                m_sum += d;
                m_cnt++;
            end else begin
                t = m_sum + d - q;
                if (t < 0) begin t = 0; m_err = 1; end
                if (t > SMAX) t = SMAX;
                m_sum = t;
            end
        end
    endfunction

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];

    always @(posedge clk) begin
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {err, out_valid, avg_out, sum_out};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t: got err=%0b valid=%0b avg=%0d sum=%0d, need err=%0b valid=%0b avg=%0d sum=%0d",
                         $time, a[EW-1], a[EW-2], a[SW+WIDTH-1:SW], a[SW-1:0],
                         e[EW-1], e[EW-2], e[SW+WIDTH-1:SW], e[SW-1:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit e, input bit c, input int d, input int q);
        @(negedge clk);
        en = e; clr = c; data_in = WIDTH'(d); data_dly = WIDTH'(q);
        model_step(e, c, d, q);
        exp_q.push_back({m_err, (m_cnt >= WINDOW), WIDTH'(model_avg(m_sum)), SW'(m_sum)});
    endtask

    task automatic idle_after();
        @(negedge clk);
        en = 0; clr = 0;
    endtask

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, need %0d", name, act, req);
        end
    endtask

    // Sample just after the edge that follows the last drive.
    task automatic settle();
        @(posedge clk); #2;
    endtask

    task automatic fill_const(input int n, input int v);
        for (int i = 0; i < n; i++) drive(1, 0, v, 8'hFF);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 0;
        m_sum = 0; m_cnt = 0; m_err = 0;
        hist.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            en = ~en; data_in = WIDTH'($urandom_range(0, 255));
        end
        check("reset_sum", int'(sum_out), 0);
        check("reset_avg", int'(avg_out), 0);
        check("reset_valid", int'(out_valid), 0);
        check("reset_err", int'(err), 0);
        @(negedge clk);
        en = 0; rstn = 1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int q;
        int d;
        do_reset();

        // fill: out_valid rises only after the 16th sample
        fill_const(15, 10);
        settle();
        check("fill_valid_early", int'(out_valid), 0);
        fill_const(1, 10);
        settle();
        check("fill_valid", int'(out_valid), 1);
        check("fill_sum", int'(sum_out), 160);
        check("fill_avg", int'(avg_out), 10);

        // steady state with en-low gaps
        drive(1, 0, 20, 10); settle(); check("run_sum1", int'(sum_out), 170);
        drive(0, 0, 99, 3);  settle(); check("run_hold1", int'(sum_out), 170);
        drive(1, 0, 20, 10); settle(); check("run_sum2", int'(sum_out), 180);
        drive(0, 0, 7, 200); settle(); check("run_hold2", int'(sum_out), 180);
        drive(1, 0, 20, 10); settle(); check("run_sum3", int'(sum_out), 190);

        // full-scale samples, no wrap
        drive(0, 1, 0, 0);
        fill_const(16, 255);
        settle();
        check("sat_sum", int'(sum_out), 4080);
        check("sat_avg", int'(avg_out), 255);
        drive(1, 0, 0, 255); settle(); check("sat_drop", int'(sum_out), 3825);

        // clr coincident with en in RUN
        drive(1, 1, 77, 0);
        settle();
        check("clr_sum", int'(sum_out), 0);
        check("clr_valid", int'(out_valid), 0);
        fill_const(15, 3);
        settle(); check("clr_refill_early", int'(out_valid), 0);
        fill_const(1, 3);
        settle(); check("clr_refill_valid", int'(out_valid), 1);

        // rounding at sum=40
        drive(0, 1, 0, 0);
        fill_const(8, 5);
        fill_const(8, 0);
        settle();
        check("round_sum", int'(sum_out), 40);
`ifdef EHGU_MAVG_ROUND_EN
        check("round_avg", int'(avg_out), 3);
`else
        check("round_avg", int'(avg_out), 2);
`endif

        // underflow and sticky err
        drive(0, 1, 0, 0);
        fill_const(5, 1);
        fill_const(11, 0);
        drive(1, 0, 0, 9);
        settle();
        check("uflow_sum", int'(sum_out), 0);
        check("uflow_err", int'(err), 1);
        drive(1, 0, 3, 0);
        settle();
        check("uflow_sticky", int'(err), 1);
        drive(0, 1, 0, 0);
        settle();
        check("uflow_clr", int'(err), 0);

        // reset mid-window discards the partial window
        fill_const(7, 50);
        idle_after();
        do_reset();
        fill_const(16, 1);
        settle();
        check("post_reset_sum", int'(sum_out), 16);
        check("post_reset_valid", int'(out_valid), 1);

        // randomized run with a consistent delay line
        drive(0, 1, 0, 0);
        hist.delete();
        for (int i = 0; i < 600; i++) begin
            bit e;
            bit c;
            e = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 79) == 0);
            d = $urandom_range(0, 255);
            if (hist.size() >= WINDOW) q = hist[hist.size() - WINDOW];
            else q = $urandom_range(0, 255);
            if ($urandom_range(0, 39) == 0) q = $urandom_range(0, 255);
            drive(e, c, d, q);
            if (c) hist.delete();
            else if (e) begin
                hist.push_back(d);
                if (hist.size() > WINDOW) void'(hist.pop_front());
            end
        end
        idle_after();
        repeat (3) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, need 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ehgu_mavg.md
EHGU_MAVG -- requirements
Module: ehgu_mavg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning sample width in bits (unsigned).
REQ-002 SHALL have parameter WINDOW, default 16, meaning averaging window length in accepted samples; power of two, 2..1024.
REQ-003 SHALL have port clk, input, 1, meaning single clock; all state on rising edge.
REQ-004 SHALL have port rstn, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1, meaning sample accept strobe; one sample per high cycle.
REQ-006 SHALL have port clr, input, 1, meaning synchronous restart of the window.
REQ-007 SHALL have port data_in, input, WIDTH, meaning newest sample.
REQ-008 SHALL have port data_dly, input, WIDTH, meaning sample accepted WINDOW en-cycles earlier, driven by the upstream memory delay line with SHIFT=WINDOW on the same en.
REQ-009 SHALL have port sum_out, output, WIDTH+log2(WINDOW), meaning registered running window sum.
REQ-010 SHALL have port avg_out, output, WIDTH, meaning sum_out divided by WINDOW.
REQ-011 SHALL have port out_valid, output, 1, meaning window fully populated.
REQ-012 SHALL have port err, output, 1, meaning sticky underflow flag for inconsistent data_dly.

Function
REQ-013 SHALL implement two states, FILL and RUN; reset and clr both enter FILL.
REQ-014 SHALL keep fill counter fcnt (0..WINDOW-1) in FILL; each en cycle increments it; the en cycle with fcnt==WINDOW-1 moves to RUN.
REQ-015 SHALL, on en in FILL, update sum_out <= sum_out + data_in, ignoring data_dly (delay memory contents undefined).
REQ-016 SHALL, on en in RUN, update sum_out <= sum_out + data_in - data_dly, with full-width arithmetic and one extra internal bit for the subtraction.
REQ-017 SHALL, if the RUN result would be negative, load 0 into sum_out and set err; err stays set until clr or reset.
REQ-018 SHALL hold sum_out, fcnt, state and out_valid unchanged when en is low.
REQ-019 SHALL have latency of one clock: sum_out reflects the sample accepted in cycle N from cycle N+1.
REQ-020 SHALL assert out_valid on the clock after the FILL-to-RUN transition, and hold it high while in RUN.
REQ-021 SHALL derive avg_out combinationally from sum_out, with no added latency.
REQ-022 SHALL give clr priority over en in the same cycle: sum_out=0, fcnt=0, out_valid=0, err=0, state FILL, sample discarded.
REQ-023 SHALL never wrap sum_out, since WINDOW*(2^WIDTH-1) fits its width.

Reset
REQ-024 SHALL, on rstn low, asynchronously force sum_out=0, fcnt=0, state=FILL, out_valid=0, err=0; avg_out then reads 0.
REQ-025 SHALL resume in FILL on release of rstn mid-operation, discarding any partial window.

Configuration
REQ-026 SHALL, with macro EHGU_MAVG_ROUND_EN defined, compute avg_out = (sum_out + WINDOW/2) >> log2(WINDOW), round-half-up; the result cannot exceed 2^WIDTH-1.
REQ-027 SHALL, without EHGU_MAVG_ROUND_EN, compute avg_out = sum_out >> log2(WINDOW), truncating.

Verification (WIDTH=8, WINDOW=16)
REQ-028 SHALL cover reset: hold rstn low with en toggling -> sum_out=0, avg_out=0, out_valid=0, err=0.
REQ-029 SHALL cover fill: 16 en cycles with data_in=10 and data_dly=0xFF -> out_valid rises the cycle after the 16th; sum_out=160; avg_out=10.
REQ-030 SHALL cover steady state: in RUN, data_in=20, data_dly=10 for 3 en cycles, with en low for 2 cycles interleaved -> sum_out 170, 180, 190, holding during en-low cycles.
REQ-031 SHALL cover saturation: 16 samples of 255 -> sum_out=4080, avg_out=255, no wrap; then data_dly=255, data_in=0 -> sum_out=3825.
REQ-032 SHALL cover clr with en in RUN -> next cycle sum_out=0, out_valid=0; 16 further en cycles are needed before out_valid returns.
REQ-033 SHALL cover rounding and underflow: sum_out=40 -> avg_out=3 with macro, 2 without; RUN with sum_out=5, data_in=0, data_dly=9 -> sum_out=0, err=1 until clr.
